multicycle_control_unit: RTL

//  Multicycle FSM sequencing the RV64 datapath: fetch, decode, execute, memory, writeback.

---
 rtl/multicycle_control_unit.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM for the RV64 datapath: fetch, decode, execute, memory, writeback.
// Strobes come from the current state and the latched opcode class. The memory handshake
// (mem_ready) and the branch condition (funct3, alu_zero) qualify them within a state.
module multicycle_control_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic [2:0] imm_sel,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       illegal,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERROR  = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    C_NONE   = 3'd0,
    C_R      = 3'd1,
    C_IALU   = 3'd2,
    C_LOAD   = 3'd3,
    C_STORE  = 3'd4,
    C_BRANCH = 3'd5,
    C_LUI    = 3'd6
  } cls_t;

  state_t           st_q, st_d;
  cls_t             cls_q, cls_dec, cls_cur;
  logic [CNT_W-1:0] cnt_q;
  logic             timeout;
  logic             br_taken;
  logic             br_bad;

  // Opcode class decode from the live IR field
  always_comb begin
    cls_dec = C_NONE;
    case (opcode)
      7'b0110011: cls_dec = C_R;
      7'b0010011: cls_dec = C_IALU;
      7'b0000011: cls_dec = C_LOAD;
      7'b0100011: cls_dec = C_STORE;
      7'b1100011: cls_dec = C_BRANCH;
      7'b0110111: cls_dec = C_LUI;
      default:    cls_dec = C_NONE;
    endcase
  end

  // In DECODE the class is not latched yet, so use the live decode
  assign cls_cur  = (st_q == S_DECODE) ? cls_dec : cls_q;
  assign timeout  = (cnt_q == CNT_W'(TIMEOUT_CYCLES));
  assign br_taken = ((funct3 == 3'b000) && alu_zero) || ((funct3 == 3'b001) && !alu_zero);
  assign br_bad   = (funct3[2:1] != 2'b00);
  assign state    = st_q;

  // State register, latched class and memory wait counter
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q  <= S_FETCH;
      cls_q <= C_NONE;
      cnt_q <= '0;
    end else begin
      st_q <= st_d;
      if (st_q == S_DECODE) cls_q <= cls_dec;
      if (st_d != st_q) cnt_q <= '0;
      else if (((st_q == S_FETCH) || (st_q == S_MEM)) && !mem_ready) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Next state and strobes; everything held inactive while reset is asserted
  always_comb begin
    st_d       = st_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    imm_sel    = 3'd7;
    alu_src_b  = 2'd0;
    alu_op     = 2'd0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;
    if (!reset) begin
      case (cls_cur)
        C_IALU, C_LOAD: if (st_q != S_FETCH && st_q != S_ERROR) imm_sel = 3'd0;
        C_STORE:        if (st_q != S_FETCH && st_q != S_ERROR) imm_sel = 3'd1;
        C_BRANCH:       if (st_q != S_FETCH && st_q != S_ERROR) imm_sel = 3'd2;
        C_LUI:          if (st_q != S_FETCH && st_q != S_ERROR) imm_sel = 3'd3;
        default:        imm_sel = 3'd7;
      endcase
      case (st_q)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            st_d     = S_DECODE;
          end else if (timeout) begin
            st_d = S_ERROR;
          end
        end
        S_DECODE: st_d = (cls_dec == C_NONE) ? S_ERROR : S_EXEC;
        S_EXEC: begin
          case (cls_cur)
            C_R:      begin alu_src_b = 2'd0; alu_op = 2'd2; st_d = S_WB;  end
            C_IALU:   begin alu_src_b = 2'd1; alu_op = 2'd2; st_d = S_WB;  end
            C_LOAD,
            C_STORE:  begin alu_src_b = 2'd1; alu_op = 2'd0; st_d = S_MEM; end
            C_LUI:    begin alu_src_b = 2'd1; alu_op = 2'd3; st_d = S_WB;  end
            C_BRANCH: begin
              alu_src_b = 2'd0;
              alu_op    = 2'd1;
              if (br_bad) begin
                st_d = S_ERROR;
              end else begin
                pc_write = br_taken;
                pc_src   = br_taken;
                st_d     = S_FETCH;
              end
            end
            default:  st_d = S_ERROR;
          endcase
        end
        S_MEM: begin
          mem_req = 1'b1;
          mem_we  = (cls_cur == C_STORE);
          if (mem_ready)    st_d = (cls_cur == C_LOAD) ? S_WB : S_FETCH;
          else if (timeout) st_d = S_ERROR;
        end
        S_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = (cls_cur == C_LOAD);
          st_d       = S_FETCH;
        end
        S_ERROR: illegal = 1'b1;
        default: st_d = S_ERROR;
      endcase
    end
  end

endmodule
